fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch front end for the single-cycle RISC-V core.
- Owns the program counter and issues word reads to instruction memory.
- Presents one instruction at a time, with its PC, to decode/execute through a valid/ready handshake.
- Consumes the branch/jump resolution (PCSrc, Jalr, targets) returned by the controller/datapath, so it is the producer side of the controller's PC-select interface.
- Holds a one-entry sequential prefetch and kills it on redirect.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  read request; memory accepts every request in the cycle it is asserted.
- imem_addr  out  XLEN  word-aligned read address; valid while imem_req=1.
- imem_rvalid  in  1  read data valid; at most one response per request, latency >=1 cycle.
- imem_rdata  in  32  instruction word; valid with imem_rvalid.
- Instr  out  32  presented instruction.
- PC  out  XLEN  address of Instr.
- PCPlus4  out  XLEN  PC+4, combinational from PC.
- instr_valid  out  1  Instr/PC are valid.
- instr_ready  in  1  execute consumes Instr this cycle.
- PCSrc  in  1  consumed instruction redirects; sampled only on consume.
- Jalr  in  1  redirect target is register-based.
- ImmExt  in  XLEN  branch/jal offset.
- ALUResult  in  XLEN  jalr target (rs1+imm).

Behaviour:
- Reset values: instr_valid=0, imem_req=0, Instr=32'h0000_0013 (nop), PC=RESET_PC, fetch_pc=RESET_PC, prefetch empty, kill=0, state=FETCH.
- At most one memory request outstanding at any time; imem_req is never asserted while a response is pending.
- Consume means instr_valid & instr_ready.
- Target on consume:
  - PCSrc=1, Jalr=0: PC+ImmExt, modulo 2^XLEN.
  - PCSrc=1, Jalr=1: {ALUResult[XLEN-1:1],1'b0}.
  - PCSrc=0: PC+4.
  - Bits [1:0] of every issued address are forced to 0.
- FETCH:
  - imem_req=1, imem_addr=fetch_pc, go to WAIT.
  - First request occurs the cycle after reset deasserts.
- WAIT (demand fetch pending):
  - On rvalid with kill=0: Instr=rdata, PC=fetch_pc, instr_valid=1 next cycle, go to VALID.
  - On rvalid with kill=1: drop the data, clear kill, go to FETCH at the stored redirect fetch_pc.
- VALID:
  - If no prefetch is pending or held, issue one request to PC+4 (one cycle of imem_req) and mark it pending.
  - A prefetch response arriving without a consume is stored in the prefetch buffer.
- On consume with PCSrc=0:
  - Prefetch held: present it the next cycle (PC+=4, stay VALID, no bubble).
  - Prefetch response arriving in the same cycle: forward it directly, same result.
  - Prefetch pending: instr_valid=0, go to WAIT (the pending request becomes the demand fetch).
  - No prefetch: fetch_pc=PC+4, go to FETCH.
- On consume with PCSrc=1:
  - instr_valid=0 and the held prefetch is discarded.
  - fetch_pc=target.
  - Prefetch pending with no same-cycle response: kill=1, go to WAIT.
  - Otherwise go to FETCH.
  - A redirect target equal to PC+4 still discards the prefetch; no special case.
- PCSrc, Jalr, ImmExt and ALUResult are ignored when there is no consume.
- Instr and PC are stable while instr_valid=1 and instr_ready=0.
- Reset mid-operation: return to the reset values. A memory response arriving in the first cycle after reset is ignored. Memory is required to drop in-flight responses on reset.
- Throughput: 1 instruction/cycle on sequential code when memory latency is 1. A redirect costs at least 2 bubble cycles.

Decomposition:
- Shared package: fetch state encoding (FETCH, WAIT, VALID), NOP_INSTR=32'h0000_0013, RESET_PC default.
- One sub-module, fetch_next_pc: combinational target/PC+4 select. Everything else stays in fetch_unit.

Test Plan:
- Reset release, memory latency 1, instr_ready=1, PCSrc=0: addresses 0x0,0x4,0x8,0xC issued; PC sequence matches; instr_valid continuous from the 3rd cycle.
- Consume at PC=0x10 with PCSrc=1, Jalr=0, ImmExt=-8 while a prefetch of 0x14 is pending: the 0x14 response is dropped, the next request is 0x08, and the next presented PC is 0x08.
- Jalr redirect with ALUResult=0x0000_0103: request address 0x0000_0100; the stale prefetch is not presented.
- instr_ready=0 for 5 cycles at PC=0x20: Instr/PC stable, exactly one prefetch request to 0x24, held. Then ready=1 gives 0x24 presented the next cycle with no new fetch gap.
- Memory latency 3, sequential: never more than one request outstanding; PC steps by 4 on each consume.
- reset asserted while in WAIT with kill=1: next cycle outputs are at reset values and the first post-reset request is RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared constants and fetch state encoding for the fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t FETCH = 2'd0;
    localparam fetch_state_t WAIT  = 2'd1;
    localparam fetch_state_t VALID = 2'd2;

endpackage
`default_nettype wire

// File: rtl/fetch_next_pc.sv
`default_nettype none
// ============================================================================
// Module      : fetch_next_pc
// Description : Combinational sequential / branch / jalr target selection.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_next_pc
    import fetch_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_pcsrc,
    input  logic            i_jalr,
    input  logic [XLEN-1:0] i_immext,
    input  logic [XLEN-1:0] i_aluresult,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic [XLEN-1:0] o_pc_plus8,
    output logic [XLEN-1:0] o_target
);

    localparam logic [XLEN-1:0] C_FOUR  = XLEN'(4);
    localparam logic [XLEN-1:0] C_EIGHT = XLEN'(8);
    localparam logic [XLEN-1:0] C_LSB   = XLEN'(1);
    localparam logic [XLEN-1:0] C_ALIGN = XLEN'(3);

    logic [XLEN-1:0] w_sel;

    assign o_pc_plus4 = i_pc + C_FOUR;
    assign o_pc_plus8 = i_pc + C_EIGHT;

    always_comb begin
        w_sel = o_pc_plus4;
        if (i_pcsrc) begin
            if (i_jalr) begin
                w_sel = i_aluresult & ~C_LSB;
            end else begin
                w_sel = i_pc + i_immext;
            end
        end
    end

    // Instruction memory is word addressed; any misaligned target is truncated.
    assign o_target = w_sel & ~C_ALIGN;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch front end with one-entry sequential prefetch.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            PCSrc,
    input  logic            Jalr,
    input  logic [XLEN-1:0] ImmExt,
    input  logic [XLEN-1:0] ALUResult
);

    localparam logic [XLEN-1:0] C_FOUR  = XLEN'(4);
    localparam logic [XLEN-1:0] C_ALIGN = XLEN'(3);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic            r_pf_pend;
    logic            r_pf_held;
    logic [31:0]     r_pf_data;
    logic            r_kill;

    fetch_state_t    w_state;
    logic [XLEN-1:0] w_fetch_pc;
    logic [XLEN-1:0] w_pc;
    logic [31:0]     w_instr;
    logic            w_pf_pend;
    logic            w_pf_held;
    logic [31:0]     w_pf_data;
    logic            w_kill;
    logic            w_req;
    logic [XLEN-1:0] w_req_addr;

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_pc_plus8;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_fetch_plus4;
    logic            w_consume;
    logic            w_pf_rsp;

    fetch_next_pc #(
        .XLEN        (XLEN)
    ) u_next_pc (
        .i_pc        (r_pc),
        .i_pcsrc     (PCSrc),
        .i_jalr      (Jalr),
        .i_immext    (ImmExt),
        .i_aluresult (ALUResult),
        .o_pc_plus4  (w_pc_plus4),
        .o_pc_plus8  (w_pc_plus8),
        .o_target    (w_target)
    );

    assign w_fetch_plus4 = r_fetch_pc + C_FOUR;
    assign w_consume     = (r_state == VALID) && instr_ready;
    // Only a prefetch can be outstanding while an instruction is presented.
    assign w_pf_rsp      = (r_state == VALID) && r_pf_pend && imem_rvalid;

    always_comb begin
        w_state    = r_state;
        w_fetch_pc = r_fetch_pc;
        w_pc       = r_pc;
        w_instr    = r_instr;
        w_pf_pend  = r_pf_pend;
        w_pf_held  = r_pf_held;
        w_pf_data  = r_pf_data;
        w_kill     = r_kill;
        w_req      = 1'b0;
        w_req_addr = r_fetch_pc;

        case (r_state)
            FETCH: begin
                w_req      = 1'b1;
                w_req_addr = r_fetch_pc;
                w_state    = WAIT;
            end

            WAIT: begin
                if (imem_rvalid) begin
                    if (r_kill) begin
                        w_kill  = 1'b0;
                        w_state = FETCH;
                    end else begin
                        w_instr    = imem_rdata;
                        w_pc       = r_fetch_pc;
                        w_state    = VALID;
                        // Launch the next sequential word alongside the demand
                        // response so straight-line code streams at one per cycle.
                        w_req      = 1'b1;
                        w_req_addr = w_fetch_plus4;
                        w_pf_pend  = 1'b1;
                    end
                end
            end

            VALID: begin
                if (w_pf_rsp) begin
                    w_pf_held = 1'b1;
                    w_pf_data = imem_rdata;
                    w_pf_pend = 1'b0;
                end

                if (w_consume) begin
                    if (PCSrc) begin
                        w_fetch_pc = w_target;
                        w_pf_held  = 1'b0;
                        w_pf_pend  = 1'b0;
                        if (r_pf_pend && !imem_rvalid) begin
                            w_kill  = 1'b1;
                            w_state = WAIT;
                        end else begin
                            w_state = FETCH;
                        end
                    end else if (r_pf_held || w_pf_rsp) begin
                        w_pc       = w_pc_plus4;
                        w_instr    = r_pf_held ? r_pf_data : imem_rdata;
                        w_pf_held  = 1'b0;
                        w_req      = 1'b1;
                        w_req_addr = w_pc_plus8;
                        w_pf_pend  = 1'b1;
                    end else if (r_pf_pend) begin
                        // The in-flight prefetch is exactly the word needed next.
                        w_fetch_pc = w_pc_plus4;
                        w_pf_pend  = 1'b0;
                        w_state    = WAIT;
                    end else begin
                        w_fetch_pc = w_pc_plus4;
                        w_state    = FETCH;
                    end
                end else if (!r_pf_held && !r_pf_pend) begin
                    w_req      = 1'b1;
                    w_req_addr = w_pc_plus4;
                    w_pf_pend  = 1'b1;
                end
            end

            default: begin
                w_state = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= FETCH;
            r_fetch_pc <= RESET_PC;
            r_pc       <= RESET_PC;
            r_instr    <= NOP_INSTR;
            r_pf_pend  <= 1'b0;
            r_pf_held  <= 1'b0;
            r_pf_data  <= NOP_INSTR;
            r_kill     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_fetch_pc <= w_fetch_pc;
            r_pc       <= w_pc;
            r_instr    <= w_instr;
            r_pf_pend  <= w_pf_pend;
            r_pf_held  <= w_pf_held;
            r_pf_data  <= w_pf_data;
            r_kill     <= w_kill;
        end
    end

    // No request may reach memory while reset is held.
    assign imem_req    = w_req && !reset;
    assign imem_addr   = w_req_addr & ~C_ALIGN;
    assign Instr       = r_instr;
    assign PC          = r_pc;
    assign PCPlus4     = w_pc_plus4;
    assign instr_valid = (r_state == VALID);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed and random checks of fetch_unit against a memory and
//               program-order model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] C_RST_PC = 32'h0000_0000;
    localparam logic [31:0] C_NOP    = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        PCSrc;
    logic        Jalr;
    logic [31:0] ImmExt;
    logic [31:0] ALUResult;

    fetch_unit #(
        .XLEN        (32),
        .RESET_PC    (C_RST_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .Instr       (Instr),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .PCSrc       (PCSrc),
        .Jalr        (Jalr),
        .ImmExt      (ImmExt),
        .ALUResult   (ALUResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total;
    int          bad;
    int          lat;
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          outstanding;
    logic [31:0] exp_pc;
    logic [31:0] req_log[$];
    bit          was_stalled;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    bit          redir_wait;
    int          bubbles;
    int          consumed;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C3C_A5A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock cycle; entered and left at posedge+1.
    task automatic tick(input bit rdy, input bit br, input bit jr,
                        input logic [31:0] imm, input logic [31:0] alu);
        int l;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr);
                mem_busy    = 1'b0;
            end
        end
        instr_ready = rdy;
        PCSrc       = br;
        Jalr        = jr;
        ImmExt      = imm;
        ALUResult   = alu;
        #1;
        if (was_stalled) chk("stall_hold_valid", 32'(instr_valid), 32'd1);
        if (instr_valid) begin
            chk("pc_order", PC, exp_pc);
            chk("instr_data", Instr, mem_word(exp_pc));
            chk("pcplus4", PCPlus4, exp_pc + 32'd4);
            if (was_stalled) begin
                chk("stall_pc", PC, prev_pc);
                chk("stall_instr", Instr, prev_instr);
            end
            if (redir_wait) begin
                chk("redirect_bubbles", 32'(bubbles >= 2), 32'd1);
                redir_wait = 1'b0;
            end
        end else if (redir_wait) begin
            bubbles++;
        end
        if (imem_rvalid) outstanding--;
        if (imem_req) begin
            outstanding++;
            chk("one_outstanding", 32'(outstanding), 32'd1);
            chk("addr_align", imem_addr & 32'h3, 32'h0);
            req_log.push_back(imem_addr);
            l        = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
            mem_busy = 1'b1;
            mem_cnt  = l;
            mem_addr = imem_addr;
        end
        was_stalled = instr_valid && !rdy;
        prev_pc     = PC;
        prev_instr  = Instr;
        if (instr_valid && rdy) begin
            consumed++;
            if (br) begin
                exp_pc     = jr ? (alu & ~32'h3) : ((exp_pc + imm) & ~32'h3);
                redir_wait = 1'b1;
                bubbles    = 0;
            end else begin
                exp_pc = exp_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset       = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        Jalr        = 1'b0;
        ImmExt      = 32'h0;
        ALUResult   = 32'h0;
        mem_busy    = 1'b0;
        outstanding = 0;
        was_stalled = 1'b0;
        redir_wait  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_instr", Instr, C_NOP);
        chk("rst_pc", PC, C_RST_PC);
        reset  = 1'b0;
        exp_pc = C_RST_PC;
        req_log.delete();
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!instr_valid && n < budget) begin
            tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            n++;
        end
        chk("wait_valid", 32'(instr_valid), 32'd1);
    endtask

    task automatic wait_req(input int n0, input int budget);
        int n = 0;
        while (req_log.size() == n0 && n < budget) begin
            tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            n++;
        end
        chk("wait_req", 32'(req_log.size() > n0), 32'd1);
    endtask

    initial begin
        int n0;
        int n24;
        int c0;
        total    = 0;
        bad      = 0;
        consumed = 0;
        bubbles  = 0;
        lat      = 1;
        mem_addr = 32'h0;
        mem_cnt  = 0;
        prev_pc  = 32'h0;
        prev_instr = 32'h0;
        do_reset(3);

        // Sequential start-up, latency 1, always ready.
        for (int i = 0; i < 6; i++) begin
            chk("startup_valid", 32'(instr_valid), 32'(i >= 2));
            tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        chk("first_addr0", req_log[0], 32'h0);
        chk("first_addr1", req_log[1], 32'h4);
        chk("first_addr2", req_log[2], 32'h8);
        chk("first_addr3", req_log[3], 32'hC);

        // Branch back by 8 from 0x10 while the 0x14 prefetch is in flight.
        chk("pc_at_branch", PC, 32'h10);
        n0 = req_log.size();
        tick(1'b1, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0);
        wait_req(n0, 10);
        chk("branch_req", req_log[n0], 32'h08);
        wait_valid(10);
        chk("branch_pc", PC, 32'h08);

        // Stall at 0x20 with the 0x24 prefetch held.
        for (int i = 0; i < 20 && !(instr_valid && PC == 32'h20); i++)
            tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("reach_0x20", PC, 32'h20);
        n0 = req_log.size();
        repeat (5) tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("stall_no_new_req", 32'(req_log.size() - n0), 32'd0);
        n24 = 0;
        foreach (req_log[k]) if (req_log[k] == 32'h24) n24++;
        chk("single_req_0x24", 32'(n24), 32'd1);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("held_valid", 32'(instr_valid), 32'd1);
        chk("held_pc", PC, 32'h24);

        // Register-based jump; low bits of the target are cleared.
        n0 = req_log.size();
        tick(1'b1, 1'b1, 1'b1, 32'h0, 32'h0000_0103);
        wait_req(n0, 10);
        chk("jalr_req", req_log[n0], 32'h0000_0100);
        wait_valid(10);
        chk("jalr_pc", PC, 32'h0000_0100);

        // Sequential stream at latency 3.
        lat = 3;
        c0  = consumed;
        repeat (30) tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("lat3_progress", 32'(consumed > c0 + 4), 32'd1);

        // Redirect straight out of a fresh demand fetch, then reset while killed.
        wait_valid(20);
        tick(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
        wait_valid(20);
        tick(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
        do_reset(1);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("post_reset_req_cnt", 32'(req_log.size()), 32'd1);
        chk("post_reset_addr", req_log[0], C_RST_PC);

        // Random traffic with random memory latency.
        lat = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset(2);
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 511)) - 32'd256, $urandom);
        end
        chk("random_progress", 32'(consumed > 300), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
